msg_schedule_stream: RTL

//  Streaming SHA-2 message-schedule generator. Accepts one 16-word block and emits
//  W[0..ROUNDS-1], one word per WValid/WReady handshake, to the compression round.

---
 rtl/msg_schedule_stream.sv | 91 +++++++++
 1 files changed

// File: rtl/msg_schedule_stream.sv
// Streaming SHA-2 message-schedule generator: one 16-word block in, W[0..ROUNDS-1] out.
// Optional WRound index output enabled by defining MSG_SCHED_ROUND_OUT_EN.
module msg_schedule_stream #(
  parameter  int WORD_W = 32,
  parameter  int ROUNDS = 64,
  localparam int CNT_W  = $clog2(ROUNDS)
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 BlkValid,
  output logic                 BlkReady,
  input  logic [16*WORD_W-1:0] BlkData,
  output logic                 WValid,
  input  logic                 WReady,
  output logic [WORD_W-1:0]    WOut,
  output logic                 WLast,
  output logic                 Busy
`ifdef MSG_SCHED_ROUND_OUT_EN
  ,
  output logic [CNT_W-1:0]     WRound
`endif
);

  generate
    if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
      $error("msg_schedule_stream: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > 80) begin : g_bad_rounds
      $error("msg_schedule_stream: ROUNDS must be in 16..80");
    end
  endgenerate

  // Sigma rotate/shift amounts for the selected hash width.
  localparam int S0A = (WORD_W == 32) ? 7  : 1;
  localparam int S0B = (WORD_W == 32) ? 18 : 8;
  localparam int S0C = (WORD_W == 32) ? 3  : 7;
  localparam int S1A = (WORD_W == 32) ? 17 : 19;
  localparam int S1B = (WORD_W == 32) ? 19 : 61;
  localparam int S1C = (WORD_W == 32) ? 10 : 6;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]               state;
  logic [15:0][WORD_W-1:0]  win;
  logic [CNT_W-1:0]         cnt;
  logic                     last;
  logic [WORD_W-1:0]        sig0, sig1, w_next;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  assign sig0   = rotr(win[1], S0A) ^ rotr(win[1], S0B) ^ (win[1] >> S0C);
  assign sig1   = rotr(win[14], S1A) ^ rotr(win[14], S1B) ^ (win[14] >> S1C);
  assign w_next = sig1 + win[9] + sig0 + win[0];
  assign last   = (state == RUN) && (cnt == CNT_W'(ROUNDS - 1));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      win   <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (BlkValid) begin
        win   <= BlkData;
        cnt   <= '0;
        state <= RUN;
      end
    end else if (WReady) begin
      // Slide the window every handshake; words beyond ROUNDS are simply never shown.
      win <= {w_next, win[15:1]};
      if (last) begin
        cnt   <= '0;
        state <= IDLE;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign BlkReady = (state == IDLE);
  assign WValid   = (state == RUN);
  assign Busy     = (state == RUN);
  assign WOut     = win[0];
  assign WLast    = last;
`ifdef MSG_SCHED_ROUND_OUT_EN
  assign WRound   = cnt;
`endif

endmodule
